// File: rtl/wb_ddr_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encodings, grant index width, Wishbone CTI codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_ddr_arbiter_pkg;

  // Grant/last index width; covers up to 4 masters.
  localparam int GW = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Wishbone registered-feedback cycle type identifiers.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping.
// Latency: zero (pure combinational).
// Backpressure: none; `any` simply reports that at least one request is present.
module rr_prio_sel
  import wb_ddr_arbiter_pkg::*;
#(
  parameter int NM = 3
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] gnt,
  output logic          any
);

  // Scan distances NM..1 from `last`; the nearest requester is written last and wins.
  always_comb begin
    gnt = '0;
    any = |req;
    for (int k = NM; k >= 1; k--) begin
      for (int j = 0; j < NM; j++) begin
        if (req[j] && (j == ((int'(last) + k) % NM))) begin
          gnt = GW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/wb_ddr_arbiter.sv
// Round-robin Wishbone arbiter sharing the DDR slave port among NM masters; grant held per bus cycle.
// Latency: slave strobe follows a fresh request by one clock; data/ack paths are combinational.
// Backpressure: losers wait with cyc high; optional WB_ARB_WATCHDOG_EN aborts a hung slave with err.
module wb_ddr_arbiter
  import wb_ddr_arbiter_pkg::*;
#(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*32-1:0] m_dat_i,
  input  logic [NM*3-1:0]  m_cti_i,
  output logic [31:0]      m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [2:0]       s_cti_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i
);

  // Parameter sanity: the grant index is GW bits wide and the watchdog counter is 16 bits.
  if (NM < 2 || NM > 4) begin : g_bad_nm
    $error("wb_ddr_arbiter: NM must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_ddr_arbiter: TIMEOUT must be 1..65535");
  end

  arb_state_t    state_q, state_d;
  logic [GW-1:0] gnt_q, last_q;
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          wd_hit;

  logic          sel_cyc, sel_stb, sel_we;
  logic [3:0]    sel_sel;
  logic [AW-1:0] sel_adr;
  logic [31:0]   sel_dat;
  logic [2:0]    sel_cti;

  rr_prio_sel #(.NM(NM)) u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick),
    .any  (pick_vld)
  );

  // Read data is broadcast; only the granted master sees an ack to qualify it.
  assign m_dat_o = s_dat_i;

  // State and grant registers; the grant is latched only when leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NM - 1);
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_vld) begin
        gnt_q  <= pick;
        last_q <= pick;
      end
    end
  end

  // Select the granted master's request signals.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_sel = '0;
    sel_adr = '0;
    sel_dat = '0;
    sel_cti = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q == GW'(i)) begin
        sel_cyc = m_cyc_i[i];
        sel_stb = m_stb_i[i];
        sel_we  = m_we_i[i];
        sel_sel = m_sel_i[i*4 +: 4];
        sel_adr = m_adr_i[i*AW +: AW];
        sel_dat = m_dat_i[i*32 +: 32];
        sel_cti = m_cti_i[i*3 +: 3];
      end
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Count strobed cycles without a slave response; any ack/err or leaving GRANT clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_q != ST_GRANT || s_ack_i || s_err_i) begin
      wd_cnt <= '0;
    end else if (s_stb_o) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign wd_hit = (state_q == ST_GRANT) && (wd_cnt == 16'(TIMEOUT));
`else
  assign wd_hit = 1'b0;
`endif

  // Next state and bus outputs: everything idles at zero outside an active grant.
  always_comb begin
    state_d = state_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (wd_hit) begin
          // Abort: one err pulse to the owner, slave released, wait for the master to let go.
          for (int i = 0; i < NM; i++) begin
            if (gnt_q == GW'(i)) m_err_o[i] = 1'b1;
          end
          state_d = ST_DRAIN;
        end else begin
          s_cyc_o = sel_cyc;
          s_stb_o = sel_stb;
          s_we_o  = sel_we;
          s_sel_o = sel_sel;
          s_adr_o = sel_adr;
          s_dat_o = sel_dat;
          s_cti_o = sel_cti;
          // A master that has already dropped cyc receives no response.
          for (int i = 0; i < NM; i++) begin
            if (gnt_q == GW'(i)) begin
              m_ack_o[i] = s_ack_i & sel_cyc;
              m_err_o[i] = s_err_i & sel_cyc;
            end
          end
          if (!sel_cyc) state_d = ST_IDLE;
        end
      end
`ifdef WB_ARB_WATCHDOG_EN
      ST_DRAIN: begin
        if (!sel_cyc) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Directed bench for wb_ddr_arbiter: reset, latency, round-robin, bursts, aborts, async reset.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: slave ack is driven by hand in each step.
module tb_wb_ddr_arbiter;
  import wb_ddr_arbiter_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;

  logic           clk;
  logic           reset;
  logic [NM-1:0]  m_cyc, m_stb, m_we;
  logic [NM*4-1:0]  m_sel;
  logic [NM*AW-1:0] m_adr;
  logic [NM*32-1:0] m_dat;
  logic [NM*3-1:0]  m_cti;
  logic [31:0]    m_dat_o;
  logic [NM-1:0]  m_ack_o, m_err_o;
  logic           s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]     s_sel_o;
  logic [AW-1:0]  s_adr_o;
  logic [31:0]    s_dat_o;
  logic [2:0]     s_cti_o;
  logic [31:0]    s_dat_i;
  logic           s_ack_i, s_err_i;

  int tests = 0;
  int fails = 0;

  wb_ddr_arbiter #(.NM(NM), .AW(AW), .TIMEOUT(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_sel_i (m_sel),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_cti_i (m_cti),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_cti_o (s_cti_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic set_m(input int k, input logic req, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[k] = req;
    m_stb[k] = req;
    m_we[k]  = we;
    m_sel[k*4 +: 4]   = 4'hF;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*32 +: 32] = dat;
    m_cti[k*3 +: 3]   = cti;
  endtask

  // Called on the falling edge where master k should own the bus: ack once, drop, check dead cycle.
  task automatic serve(input int k, input logic [31:0] adr);
    #1 chk($sformatf("adr_m%0d", k), s_adr_o, adr);
    s_ack_i = 1'b1;
    #1 chk($sformatf("ack_m%0d", k), 32'(m_ack_o), 32'(1) << k);
    @(negedge clk);
    s_ack_i = 1'b0;
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    #1 chk($sformatf("drop_m%0d", k), 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    #1 chk($sformatf("dead_m%0d", k), 32'(s_cyc_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  stb_cycles;
    bit  seen;
    reset = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0; m_cti = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

    // Reset state, with requests present that must be ignored.
    @(negedge clk);
    m_cyc = 3'b111; m_stb = 3'b111; s_ack_i = 1'b1;
    #1;
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_stb", 32'(s_stb_o), 32'd0);
    chk("rst_ack", 32'(m_ack_o), 32'd0);
    chk("rst_err", 32'(m_err_o), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_gnt", 32'(dut.gnt_q), 32'd0);
    chk("rst_last", 32'(dut.last_q), 32'd2);
    m_cyc = '0; m_stb = '0; s_ack_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // 1: single master read with latency and data.
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, CTI_CLASSIC);
    #1 chk("t1_stb_before", 32'(s_stb_o), 32'd0);
    @(negedge clk);
    #1 chk("t1_stb_lat1", 32'(s_stb_o), 32'd1);
    chk("t1_adr", s_adr_o, 32'h4000_0000);
    @(negedge clk);
    #1 chk("t1_noack", 32'(m_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1 chk("t1_ack", 32'(m_ack_o), 32'b010);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    @(negedge clk);
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    #1 chk("t1_drop", 32'(s_cyc_o), 32'd0);
    @(negedge clk);

    // 2: simultaneous requests after reset -> m0, m1, m2, m0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b0, 32'h200, 32'h0, CTI_CLASSIC);
    set_m(2, 1'b1, 1'b0, 32'h300, 32'h0, CTI_CLASSIC);
    #1 chk("t2_idle", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    serve(0, 32'h100);
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    serve(1, 32'h200);
    @(negedge clk);
    serve(2, 32'h300);
    @(negedge clk);
    serve(0, 32'h100);

    // 3: m1 incrementing burst holds the grant against m0.
    set_m(1, 1'b1, 1'b0, 32'h1000, 32'h0, CTI_INCR);
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 32'h6000, 32'h0, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      set_m(1, 1'b1, 1'b0, 32'h1000 + 32'(4 * b), 32'h0, (b == 3) ? CTI_EOB : CTI_INCR);
      s_ack_i = 1'b1; s_dat_i = 32'h100 + 32'(b);
      #1;
      chk($sformatf("t3_ack_b%0d", b), 32'(m_ack_o), 32'b010);
      chk($sformatf("t3_adr_b%0d", b), s_adr_o, 32'h1000 + 32'(4 * b));
      chk($sformatf("t3_cti_b%0d", b), 32'(s_cti_o), (b == 3) ? 32'b111 : 32'b010);
    end
    @(negedge clk);
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    #1 chk("t3_drop", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    #1 chk("t3_dead", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    serve(0, 32'h6000);

    // 4: stray ack in IDLE, then m2 abandons and m1 is granted next.
    s_ack_i = 1'b1;
    #1 chk("t4_stray", 32'(m_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0;
    set_m(2, 1'b1, 1'b0, 32'h2000, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    #1 chk("t4_m2_adr", s_adr_o, 32'h2000);
    @(negedge clk);
    set_m(2, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b0, 32'h3000, 32'h0, CTI_CLASSIC);
    #1 chk("t4_abandon", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b1;
    #1 chk("t4_late_ack", 32'(m_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0;
    serve(1, 32'h3000);

    // 5: asynchronous reset during an m0 write while m1 waits.
    set_m(0, 1'b1, 1'b1, 32'h5000, 32'hCAFE_F00D, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b0, 32'h7000, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    #1;
    chk("t5_we", 32'(s_we_o), 32'd1);
    chk("t5_wdat", s_dat_o, 32'hCAFE_F00D);
    reset = 1'b1;
    #1;
    chk("t5_async_cyc", 32'(s_cyc_o), 32'd0);
    chk("t5_async_stb", 32'(s_stb_o), 32'd0);
    chk("t5_gnt", 32'(dut.gnt_q), 32'd0);
    chk("t5_last", 32'(dut.last_q), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    serve(0, 32'h5000);
    @(negedge clk);
    serve(1, 32'h7000);

`ifdef WB_ARB_WATCHDOG_EN
    // 6: hung slave; err after 16 strobed cycles, drain, then recovery.
    set_m(2, 1'b1, 1'b0, 32'h8000, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    stb_cycles = 0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      #1;
      if (m_err_o != '0) seen = 1'b1;
      else begin
        if (s_stb_o) stb_cycles++;
        @(negedge clk);
      end
    end
    chk("t6_seen", 32'(seen), 32'd1);
    chk("t6_cycles", 32'(stb_cycles), 32'd16);
    chk("t6_err", 32'(m_err_o), 32'b100);
    chk("t6_cyc", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b1;
    #1;
    chk("t6_drain_ack", 32'(m_ack_o), 32'd0);
    chk("t6_drain_err", 32'(m_err_o), 32'd0);
    chk("t6_drain_cyc", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0;
    set_m(2, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    #1 chk("t6_idle", 32'(dut.state_q), 32'(ST_IDLE));
    set_m(0, 1'b1, 1'b0, 32'h9000, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    serve(0, 32'h9000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
